mux_scan_ctrl: RTL and testbench

Sequencer that sits directly around the 16:1 channel mux (mux_16to1).
- Drives the mux `sel` input.
- Steps through an enabled subset of the 16 channels in ascending order.
- Registers each mux output sample and presents it downstream on a valid/ready stream tagged with the channel number.
- Supports single-pass and continuous (wrap-around) scanning.

---
 rtl/mux_scan_pkg.sv | 42 ++++
 rtl/mux_scan_if.sv | 43 ++++
 rtl/mux_scan_next_find.sv | 26 ++
 rtl/mux_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scan_ctrl channel sequencer.
// Holds the channel count, select width, FSM state enum and the next-enabled-channel search.
package mux_scan_pkg;

  localparam int NCH   = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    OUT
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } next_t;

  // Lowest enabled index strictly above cur; with wrap, falls back to the lowest enabled overall.
  function automatic next_t next_en(input logic [NCH-1:0] mask,
                                    input logic [SEL_W-1:0] cur,
                                    input logic wrap);
    next_t r;
    r = '{found: 1'b0, idx: '0};
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        r.found = 1'b1;
        r.idx   = SEL_W'(i);
      end
    end
    if (!r.found && wrap) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (mask[i]) begin
          r.found = 1'b1;
          r.idx   = SEL_W'(i);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_if.sv
// Mux-side select/data and downstream valid/ready sample stream of mux_scan_ctrl.
// MUX_SCAN_PARITY_EN adds the out_parity signal to the stream.
interface mux_scan_if
  import mux_scan_pkg::*;
#(
  parameter int W = 8
);

  logic [SEL_W-1:0] sel;
  logic [W-1:0]     mux_out;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_ch;
  logic             out_valid;
  logic             out_ready;
`ifdef MUX_SCAN_PARITY_EN
  logic             out_parity;
`endif

  modport master (
    output sel,
    input  mux_out,
    output out_data,
    output out_ch,
    output out_valid,
`ifdef MUX_SCAN_PARITY_EN
    output out_parity,
`endif
    input  out_ready
  );

  modport slave (
    input  sel,
    output mux_out,
    input  out_data,
    input  out_ch,
    input  out_valid,
`ifdef MUX_SCAN_PARITY_EN
    input  out_parity,
`endif
    output out_ready
  );

endinterface

// File: rtl/mux_scan_next_find.sv
// Combinational priority finder: next enabled channel above cur_i and the lowest enabled channel.
module mux_scan_next_find
  import mux_scan_pkg::*;
(
  input  logic [NCH-1:0]   mask_i,
  input  logic [SEL_W-1:0] cur_i,
  output logic [SEL_W-1:0] next_idx_o,
  output logic [SEL_W-1:0] low_idx_o,
  output logic             has_higher_o,
  output logic             any_o
);

  next_t hi;
  next_t lo;

  always_comb begin
    hi = next_en(mask_i, cur_i, 1'b0);
    // Nothing lies above the top index, so a wrapping search from there yields the lowest.
    lo = next_en(mask_i, SEL_W'(NCH - 1), 1'b1);
    next_idx_o   = hi.idx;
    has_higher_o = hi.found;
    low_idx_o    = lo.idx;
    any_o        = lo.found;
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer around a 16:1 mux: drives sel, registers samples onto a valid/ready stream.
// Optional MUX_SCAN_PARITY_EN adds a registered even-parity bit alongside out_data.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           stop,
  input  logic           cont,
  input  logic [NCH-1:0] ch_mask,
  output logic           busy,
  output logic           done,
  mux_scan_if.master     bus
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [W-1:0]     data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic             cont_q, cont_d;
  logic             stop_pend_q, stop_pend_d;

  logic [NCH-1:0]   find_mask;
  logic [SEL_W-1:0] next_idx, low_idx;
  logic             has_higher, any_en;
  logic             stop_now;

  // IDLE searches the live mask for the first channel; a running scan uses the latched copy.
  assign find_mask = (state_q == IDLE) ? ch_mask : mask_q;
  assign stop_now  = stop_pend_q | stop;

  mux_scan_next_find u_find (
    .mask_i      (find_mask),
    .cur_i       (sel_q),
    .next_idx_o  (next_idx),
    .low_idx_o   (low_idx),
    .has_higher_o(has_higher),
    .any_o       (any_en)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    state_d     = state_q;
    sel_d       = sel_q;
    data_d      = data_q;
    ch_d        = ch_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    mask_d      = mask_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;

    if (state_q != IDLE && stop) stop_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start && any_en) begin
          mask_d      = ch_mask;
          cont_d      = cont;
          sel_d       = low_idx;
          stop_pend_d = 1'b0;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        data_d  = bus.mux_out;
        ch_d    = sel_q;
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          if (!stop_now && has_higher) begin
            sel_d   = next_idx;
            state_d = SETTLE;
          end else if (!stop_now && cont_q) begin
            sel_d   = low_idx;
            state_d = SETTLE;
          end else begin
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      data_q      <= '0;
      ch_q        <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      mask_q      <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      ch_q        <= ch_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      mask_q      <= mask_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    parity_q <= 1'b0;
    else if (state_q == SETTLE) parity_q <= ^bus.mux_out;
  end

  assign bus.out_parity = parity_q;
`endif

  assign bus.sel       = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: directed scenarios plus randomized single-pass scans.
// The expected sample stream is derived from the enable mask and the channel input table.
module tb_mux_scan_ctrl;

  typedef struct packed {
    logic [3:0] ch;
    logic [7:0] data;
  } smp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, cont;
  logic [15:0] ch_mask;
  logic        out_ready;
  logic        busy, done;
  logic [7:0]  inp [16];

  int   n_checks = 0;
  int   n_err    = 0;
  int   done_cnt = 0;
  smp_t got_q[$];
  smp_t exp_q[$];

  bit         hold_pend = 1'b0;
  logic [3:0] h_ch, h_sel;
  logic [7:0] h_data;

  mux_scan_if #(.W(8)) bus ();

  assign bus.mux_out   = inp[bus.sel];
  assign bus.out_ready = out_ready;

  mux_scan_ctrl #(.W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .cont   (cont),
    .ch_mask(ch_mask),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observer on the falling edge: records handshakes, counts done pulses, enforces hold under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (hold_pend) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_ch",    32'(bus.out_ch),    32'(h_ch));
        check("hold_data",  32'(bus.out_data),  32'(h_data));
        check("hold_sel",   32'(bus.sel),       32'(h_sel));
      end
      hold_pend = bus.out_valid && !out_ready;
      h_ch      = bus.out_ch;
      h_data    = bus.out_data;
      h_sel     = bus.sel;
      if (bus.out_valid && out_ready) begin
        got_q.push_back('{ch: bus.out_ch, data: bus.out_data});
`ifdef MUX_SCAN_PARITY_EN
        check("parity", 32'(bus.out_parity), 32'(^inp[bus.out_ch]));
`endif
      end
    end
  end

  task automatic build_exp(input logic [15:0] mask, input int rounds);
    exp_q.delete();
    for (int r = 0; r < rounds; r++)
      for (int c = 0; c < 16; c++)
        if (mask[c]) exp_q.push_back('{ch: 4'(c), data: inp[c]});
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_ch"},   32'(got_q[i].ch),   32'(exp_q[i].ch));
      check({tag, "_data"}, 32'(got_q[i].data), 32'(exp_q[i].data));
    end
    got_q.delete();
  endtask

  task automatic start_scan(input logic [15:0] mask, input logic c);
    ch_mask = mask;
    cont    = c;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  // Runs until a done pulse is seen (bounded), then confirms exactly one pulse and an idle block.
  task automatic run_until_done(input string tag, input int budget, input bit rnd_ready);
    int n0 = done_cnt;
    int i  = 0;
    while (done_cnt == n0 && i < budget) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      step();
      i++;
    end
    out_ready = 1'b1;
    repeat (3) step();
    check({tag, "_done_once"}, 32'(done_cnt - n0), 32'd1);
    check({tag, "_idle"},      32'(busy),          32'd0);
  endtask

  initial begin
    logic [15:0] m;
    int          n0;

    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; ch_mask = '0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) inp[i] = 8'(8'h10 * i + i + 1);
    #12;
    check("rst_sel",   32'(bus.sel),       32'd0);
    check("rst_data",  32'(bus.out_data),  32'd0);
    check("rst_ch",    32'(bus.out_ch),    32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",  32'(busy),          32'd0);
    check("rst_done",  32'(done),          32'd0);
    step();
    rst = 1'b0;
    step();

    // Single channel, single pass, exact latency.
    n0 = done_cnt;
    start_scan(16'h0001, 1'b0);
    check("s1_sel_c1",   32'(bus.sel),       32'd0);
    check("s1_busy_c1",  32'(busy),          32'd1);
    check("s1_valid_c1", 32'(bus.out_valid), 32'd0);
    step();
    check("s1_valid_c2", 32'(bus.out_valid), 32'd1);
    check("s1_ch_c2",    32'(bus.out_ch),    32'd0);
    check("s1_data_c2",  32'(bus.out_data),  32'(inp[0]));
    step();
    check("s1_done",     32'(done),          32'd1);
    check("s1_valid_c3", 32'(bus.out_valid), 32'd0);
    step();
    check("s1_done_low", 32'(done),          32'd0);
    check("s1_busy_low", 32'(busy),          32'd0);
    check("s1_done_cnt", 32'(done_cnt - n0), 32'd1);
    build_exp(16'h0001, 1);
    compare_stream("s1");

    // Sparse mask; start, mask and cont changes while busy must be ignored.
    start_scan(16'h8421, 1'b0);
    ch_mask = 16'hFFFF; cont = 1'b1; start = 1'b1;
    step(); step();
    start = 1'b0;
    run_until_done("s2", 40, 1'b0);
    build_exp(16'h8421, 1);
    compare_stream("s2");

    // Continuous two-channel scan, stop pulsed in the SETTLE of the third ch 2.
    start_scan(16'h0006, 1'b1);
    for (int i = 0; i < 40 && !(got_q.size() == 5 && busy && !bus.out_valid); i++) step();
    check("s3_at_settle", 32'(got_q.size() == 5 && busy && !bus.out_valid), 32'd1);
    check("s3_sel2",      32'(bus.sel), 32'd2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    run_until_done("s3", 20, 1'b0);
    build_exp(16'h0006, 3);
    compare_stream("s3");

    // Backpressure at ch 5 for five cycles.
    start_scan(16'h8421, 1'b0);
    for (int i = 0; i < 20 && !(bus.out_valid && bus.out_ch == 4'd5); i++) step();
    check("s4_reach_ch5", 32'(bus.out_valid && bus.out_ch == 4'd5), 32'd1);
    out_ready = 1'b0;
    repeat (5) step();
    check("s4_sel_held", 32'(bus.sel),    32'd5);
    check("s4_ch_held",  32'(bus.out_ch), 32'd5);
    out_ready = 1'b1;
    run_until_done("s4", 40, 1'b0);
    build_exp(16'h8421, 1);
    compare_stream("s4");

    // Empty mask is ignored; stop in IDLE has no lasting effect.
    n0 = done_cnt;
    start_scan(16'h0000, 1'b0);
    check("s5_busy", 32'(busy), 32'd0);
    step();
    check("s5_done", 32'(done_cnt - n0), 32'd0);
    check("s5_valid", 32'(bus.out_valid), 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    start_scan(16'h0003, 1'b0);
    run_until_done("s5", 20, 1'b0);
    build_exp(16'h0003, 1);
    compare_stream("s5");

    // Randomized masks, data and downstream readiness.
    for (int k = 0; k < 6; k++) begin
      m = 16'($urandom());
      if (m == 16'h0) m = 16'h0010;
      for (int i = 0; i < 16; i++) inp[i] = 8'($urandom());
      start_scan(m, 1'b0);
      run_until_done("rnd", 400, 1'b1);
      build_exp(m, 1);
      compare_stream("rnd");
    end

    // Asynchronous reset while holding a sample in OUT.
    inp[3]    = 8'h07;
    out_ready = 1'b0;
    start_scan(16'h0008, 1'b1);
    step();
    check("s6_valid", 32'(bus.out_valid), 32'd1);
    check("s6_data",  32'(bus.out_data),  32'h07);
`ifdef MUX_SCAN_PARITY_EN
    check("s6_parity", 32'(bus.out_parity), 32'd1);
`endif
    n0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("s6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("s6_rst_data",  32'(bus.out_data),  32'd0);
    check("s6_rst_ch",    32'(bus.out_ch),    32'd0);
    check("s6_rst_sel",   32'(bus.sel),       32'd0);
    check("s6_rst_busy",  32'(busy),          32'd0);
    check("s6_rst_done",  32'(done),          32'd0);
`ifdef MUX_SCAN_PARITY_EN
    check("s6_rst_parity", 32'(bus.out_parity), 32'd0);
`endif
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("s6_no_done", 32'(done_cnt - n0), 32'd0);
    check("s6_idle",    32'(busy),          32'd0);
    got_q.delete();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
